// File: rtl/spi_host_pkg.sv
// Shared constants and FSM state encoding for the spi_host SPI initiator.
package spi_host_pkg;

  localparam int SPI_WORD_BITS = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_host_phase.sv
// Phase timer for spi_host: a reloadable down-counter whose zero count marks the
// last cycle of a phase, plus the count of bits still to be clocked.
module spi_host_phase #(
  parameter int CNT_W     = 2,
  parameter int WORD_BITS = 64,
  parameter int BIT_W     = $clog2(WORD_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             bit_load,
  input  logic             bit_dec,
  output logic             expire,
  output logic [BIT_W-1:0] bits_left
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bits_q, bits_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    bits_d = bits_q;
    if (bit_load) begin
      bits_d = BIT_W'(WORD_BITS);
    end else if (bit_dec) begin
      bits_d = bits_q - BIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      bits_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bits_q <= bits_d;
    end
  end

  assign expire    = (cnt_q == '0);
  assign bits_left = bits_q;

endmodule

// File: rtl/spi_host.sv
// spi_host: mode-0 SPI initiator sending one WORD_BITS word per frame, MSB first.
// With burst latched, CS stays low straight into the next word.
module spi_host
  import spi_host_pkg::*;
#(
  parameter int WORD_BITS = SPI_WORD_BITS,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 2
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 burst,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO
);

  localparam int MAX_CNT = max_int(max_int(CLK_DIV, CS_SETUP), max_int(CS_HOLD, CS_IDLE));
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = $clog2(WORD_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(CS_IDLE - 1);

  state_e                 state_q, state_d;
  logic [WORD_BITS-2:0]   tx_shift_q, tx_shift_d;
  logic [WORD_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [WORD_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   burst_q, burst_d;
  logic                   sck_q, sck_d;
  logic                   cs_q, cs_d;
  logic                   copi_q, copi_d;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_val;
  logic                   bit_load;
  logic                   bit_dec;
  logic                   expire;
  logic [BIT_W-1:0]       bits_left;
  logic                   accept;

  spi_host_phase #(
    .CNT_W     (CNT_W),
    .WORD_BITS (WORD_BITS),
    .BIT_W     (BIT_W)
  ) u_phase (
    .clk       (CLK),
    .reset     (reset),
    .load      (cnt_load),
    .load_val  (cnt_val),
    .bit_load  (bit_load),
    .bit_dec   (bit_dec),
    .expire    (expire),
    .bits_left (bits_left)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    burst_d    = burst_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    copi_d     = copi_q;
    tx_ready   = 1'b0;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = DIV_LOAD;
    bit_load   = 1'b0;
    bit_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        accept   = tx_valid;
      end
      ST_SETUP: begin
        if (expire) begin
          state_d  = ST_HIGH;
          sck_d    = 1'b1;
          cnt_load = 1'b1;
        end
      end
      // CIPO is sampled at the very end of the high phase to give the responder
      // the longest possible time after the previous SCK fall.
      ST_HIGH: begin
        if (expire) begin
          rx_shift_d = {rx_shift_q[WORD_BITS-2:0], CIPO};
          sck_d      = 1'b0;
          bit_dec    = 1'b1;
          state_d    = ST_LOW;
          cnt_load   = 1'b1;
          if (bits_left != BIT_W'(1)) begin
            copi_d     = tx_shift_q[WORD_BITS-2];
            tx_shift_d = {tx_shift_q[WORD_BITS-3:0], 1'b0};
          end
        end
      end
      ST_LOW: begin
        if (expire) begin
          cnt_load = 1'b1;
          if (bits_left != '0) begin
            state_d = ST_HIGH;
            sck_d   = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_val = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (expire) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          if (burst_q && tx_valid) begin
            tx_ready = 1'b1;
            accept   = 1'b1;
          end else begin
            cs_d     = 1'b1;
            copi_d   = 1'b0;
            state_d  = ST_GAP;
            cnt_load = 1'b1;
            cnt_val  = IDLE_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (expire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The MSB goes straight to COPI; the shifter only keeps the bits still to send.
    if (accept) begin
      tx_shift_d = tx_data[WORD_BITS-2:0];
      copi_d     = tx_data[WORD_BITS-1];
      burst_d    = burst;
      cs_d       = 1'b0;
      state_d    = ST_SETUP;
      cnt_load   = 1'b1;
      cnt_val    = SETUP_LOAD;
      bit_load   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      burst_q    <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      copi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      burst_q    <= burst_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      copi_q     <= copi_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign SCK      = sck_q;
  assign CS       = cs_q;
  assign COPI     = copi_q;

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host: a per-cycle timeline model of the SPI frame
// plus directed words with hand-computed results.
module tb_spi_host;

  localparam int W       = 64;
  localparam int DIV     = 4;
  localparam int SETUP   = 2;
  localparam int HOLD    = 2;
  localparam int IDLE    = 2;
  localparam int T_FIRST = 1 + SETUP;
  localparam int T_LAST  = SETUP + 2 * DIV * W;
  localparam int T_CSLOW = T_LAST + HOLD;
  localparam int T_RXV   = T_CSLOW + 1;
  localparam int T_READY = T_RXV + IDLE;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } rx_t;

  logic          CLK;
  logic          reset;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          burst;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          busy;
  logic          SCK;
  logic          CS;
  logic          COPI;
  logic          CIPO;

  int            errors = 0;
  int            checks = 0;
  int            cipoMode = 0;

  int            cyc = 0;
  bit            active = 0;
  int            t0 = 0;
  logic [63:0]   mWord = '0;
  bit            mBurst = 0;
  logic [63:0]   rxHold = '0;
  logic [63:0]   modelResp = '0;
  rx_t           rxQ[$];

  int            sckRises = 0;
  int            csLowCnt = 0;
  int            csRises = 0;
  int            rxvCnt = 0;
  int            rxvTimes[$];
  int            csHighRun = 0;
  int            lastGap = 0;
  logic [63:0]   copiStream = '0;

  logic [63:0]   respReg = '0;
  logic [63:0]   respOut = '0;
  logic [63:0]   respIn = '0;
  logic          respBit = 1'b0;

  spi_host dut (
    .CLK      (CLK),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .burst    (burst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .SCK      (SCK),
    .CS       (CS),
    .COPI     (COPI),
    .CIPO     (CIPO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign CIPO = (cipoMode == 0) ? COPI : (cipoMode == 1) ? 1'b1 : respBit;

  // Minimal register responder: returns the word written in the previous frame.
  always @(negedge CS) begin
    respOut = respReg;
    respBit = respReg[63];
  end
  always @(negedge SCK) begin
    if (CS == 1'b0) begin
      respOut = respOut << 1;
      respBit = respOut[63];
    end
  end
  always @(posedge SCK) begin
    respIn = {respIn[62:0], COPI};
    sckRises = sckRises + 1;
    copiStream = {copiStream[62:0], COPI};
  end
  always @(posedge CS) begin
    csRises = csRises + 1;
    if (cipoMode == 2) respReg = respIn;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Frame timeline model: every output is a function of cycles since accept.
  always @(negedge CLK) begin
    int          t;
    int          k;
    logic        eCs, eSck, eCopi, eBusy, eReady, eRxv;
    logic [63:0] rxExp;
    rx_t         ent;
    cyc = cyc + 1;
    eCs = 1'b1; eSck = 1'b0; eCopi = 1'b0; eBusy = 1'b0; eReady = 1'b1; eRxv = 1'b0;
    if (reset) begin
      active = 0;
      rxQ.delete();
      rxHold = '0;
    end else begin
      if (rxQ.size() > 0 && rxQ[0].cyc == cyc) begin
        eRxv = 1'b1;
        rxHold = rxQ[0].data;
        rxQ.delete(0);
      end
      t = cyc - t0;
      if (active && t < T_READY) begin
        eBusy = 1'b1;
        eReady = 1'b0;
        if (t <= T_CSLOW) begin
          eCs = 1'b0;
          eSck = (t >= T_FIRST && t <= T_LAST && ((t - T_FIRST) % (2 * DIV)) < DIV);
          k = (t < T_FIRST + DIV) ? 0 : (t - (T_FIRST + DIV)) / (2 * DIV) + 1;
          if (k > W - 1) k = W - 1;
          eCopi = mWord[W - 1 - k];
          if (t == T_CSLOW && mBurst && tx_valid) eReady = 1'b1;
        end
      end
      if (eReady && tx_valid) begin
        if (cipoMode == 0) begin
          rxExp = tx_data;
        end else if (cipoMode == 1) begin
          rxExp = '1;
        end else begin
          rxExp = modelResp;
          modelResp = tx_data;
        end
        active = 1;
        t0 = cyc;
        mWord = tx_data;
        mBurst = burst;
        ent.cyc = cyc + T_RXV;
        ent.data = rxExp;
        rxQ.push_back(ent);
      end
    end
    if (CS == 1'b0) begin
      csLowCnt = csLowCnt + 1;
      if (csHighRun > 0) lastGap = csHighRun;
      csHighRun = 0;
    end else begin
      csHighRun = csHighRun + 1;
    end
    if (rx_valid == 1'b1) begin
      rxvCnt = rxvCnt + 1;
      rxvTimes.push_back(cyc);
    end
    checkOutput("pins{CS,SCK,COPI,busy,tx_ready,rx_valid}",
                64'({CS, SCK, COPI, busy, tx_ready, rx_valid}),
                64'({eCs, eSck, eCopi, eBusy, eReady, eRxv}));
    checkOutput("rx_data", rx_data, rxHold);
  end

  task automatic resetMeasures();
    sckRises = 0;
    csLowCnt = 0;
    csRises = 0;
    rxvCnt = 0;
    rxvTimes.delete();
    copiStream = '0;
  endtask

  // Present one word and hold it until the handshake edge, then scramble the inputs.
  task automatic applyStimulus(input logic [63:0] word, input logic b);
    bit done;
    int n;
    done = 0;
    n = 0;
    tx_data = word;
    burst = b;
    tx_valid = 1'b1;
    while (!done && n < 2000) begin
      @(negedge CLK);
      n = n + 1;
      if (tx_ready) done = 1;
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL handshake_timeout: tx_ready never seen, required within 2000 cycles");
    end
    @(posedge CLK);
    #1;
    tx_valid = 1'b0;
    tx_data = {$urandom, $urandom};
    burst = ~b;
  endtask

  task automatic waitIdle();
    bit done;
    int n;
    done = 0;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge CLK);
      n = n + 1;
      if (!busy) done = 1;
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL idle_timeout: busy still 1, required 0 within 3000 cycles");
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int n;
    int savedRxv;
    int spacing;
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    burst = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_CS", 64'(CS), 64'd1);
    checkOutput("reset_SCK", 64'(SCK), 64'd0);
    checkOutput("reset_COPI", 64'(COPI), 64'd0);
    checkOutput("reset_rx_valid", 64'(rx_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_tx_ready", 64'(tx_ready), 64'd1);
    checkOutput("reset_rx_data", rx_data, 64'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(posedge CLK);
    #1;

    $display("[TB] loopback word");
    cipoMode = 0;
    resetMeasures();
    applyStimulus(64'hDEADBEEF_01234567, 1'b0);
    waitIdle();
    checkOutput("loop_rx_data", rx_data, 64'hDEADBEEF_01234567);
    checkOutput("loop_sck_rises", 64'(sckRises), 64'd64);
    checkOutput("loop_cs_low_cycles", 64'(csLowCnt), 64'd516);
    checkOutput("loop_rx_valid_pulses", 64'(rxvCnt), 64'd1);
    checkOutput("loop_copi_stream", copiStream, 64'hDEADBEEF_01234567);

    $display("[TB] CIPO held high");
    cipoMode = 1;
    resetMeasures();
    applyStimulus(64'h8000_0000_0000_0001, 1'b0);
    waitIdle();
    checkOutput("ones_rx_data", rx_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("ones_copi_stream", copiStream, 64'h8000_0000_0000_0001);

    $display("[TB] burst of two words");
    cipoMode = 0;
    resetMeasures();
    applyStimulus(64'h1, 1'b1);
    applyStimulus(64'h2, 1'b1);
    waitIdle();
    spacing = (rxvTimes.size() >= 2) ? rxvTimes[1] - rxvTimes[0] : -1;
    checkOutput("burst_rx_valid_pulses", 64'(rxvCnt), 64'd2);
    checkOutput("burst_rx_spacing", 64'(spacing), 64'd516);
    checkOutput("burst_cs_rises", 64'(csRises), 64'd1);
    checkOutput("burst_sck_rises", 64'(sckRises), 64'd128);
    checkOutput("burst_cs_low_cycles", 64'(csLowCnt), 64'd1032);
    checkOutput("burst_last_rx_data", rx_data, 64'h2);

    $display("[TB] reset during bit 30");
    resetMeasures();
    applyStimulus(64'hA5A5_5A5A_F0F0_0F0F, 1'b0);
    checkOutput("gap_after_burst_ge2", 64'(lastGap >= 2), 64'd1);
    found = 0;
    n = 0;
    while (!found && n < 1000) begin
      @(negedge CLK);
      n = n + 1;
      if (sckRises == 31) found = 1;
    end
    checkOutput("bit30_reached", 64'(found), 64'd1);
    #1;
    checkOutput("sck_high_before_reset", 64'(SCK), 64'd1);
    savedRxv = rxvCnt;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_CS", 64'(CS), 64'd1);
    checkOutput("async_reset_SCK", 64'(SCK), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    checkOutput("tx_ready_after_reset", 64'(tx_ready), 64'd1);
    repeat (600) @(negedge CLK);
    checkOutput("no_rx_valid_after_reset", 64'(rxvCnt), 64'(savedRxv));
    @(posedge CLK);
    #1;
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0);
    waitIdle();
    checkOutput("post_reset_rx_data", rx_data, 64'h0123_4567_89AB_CDEF);

    $display("[TB] register write then read through responder");
    cipoMode = 2;
    applyStimulus(64'hCAFE_F00D_1234_5678, 1'b0);
    waitIdle();
    applyStimulus(64'h0000_0000_0000_0000, 1'b0);
    waitIdle();
    checkOutput("responder_readback", rx_data, 64'hCAFE_F00D_1234_5678);

    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
